// File: rtl/clock_divider_multi_pkg.sv
// Shared clock utilities for the multi-channel clock divider: the divide
// ratio loaded at reset and a clog2 helper used to size the channel selector.
package clock_divider_multi_pkg;

  // Divide ratio every channel holds after reset.
  localparam int unsigned DIV_RESET = 2;

  // Ceiling log2 with a floor of 1, so a single channel still gets a 1-bit selector.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/clock_divider_channel.sv
// One divider channel: pending/active ratio, enable and period counter,
// producing a one-cycle TICK per period and a registered near-50% DCLK.
module clock_divider_channel
  import clock_divider_multi_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic [WIDTH-1:0] cfg_div,
  input  logic             cfg_en,
  input  logic             sync,
  output logic             tick,
  output logic             dclk
);

  logic [WIDTH-1:0] pdiv, adiv, cnt;
  logic             en;

  logic [WIDTH-1:0] pdiv_nx, adiv_nx, cnt_nx;
  logic             en_nx, tick_nx, dclk_nx, wrap;

  // Next-state: a write lands first, so SYNC and period wraps see the new pending ratio.
  always_comb begin
    pdiv_nx = wr ? cfg_div : pdiv;
    en_nx   = wr ? cfg_en  : en;
    adiv_nx = adiv;
    cnt_nx  = '0;
    tick_nx = 1'b0;
    // Ratios below 2 wrap every cycle; otherwise wrap on the last count of the period.
    wrap    = (adiv < WIDTH'(DIV_RESET)) || (cnt >= adiv - WIDTH'(1));
    // While disabled the ratio loads straight into the active register.
    if (wr && !en) begin
      adiv_nx = cfg_div;
    end
    // Only a channel that was and stays enabled counts; enabling or disabling restarts at 0.
    if (en && en_nx) begin
      if (sync) begin
        adiv_nx = pdiv_nx;
      end else if (wrap) begin
        adiv_nx = pdiv_nx;
        tick_nx = 1'b1;
      end else begin
        cnt_nx  = cnt + WIDTH'(1);
      end
    end
    dclk_nx = en_nx && (cnt_nx < (adiv_nx >> 1));
  end

  // Channel state register; reset abandons any period in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pdiv <= WIDTH'(DIV_RESET);
      adiv <= WIDTH'(DIV_RESET);
      en   <= 1'b0;
      cnt  <= '0;
      tick <= 1'b0;
      dclk <= 1'b0;
    end else begin
      pdiv <= pdiv_nx;
      adiv <= adiv_nx;
      en   <= en_nx;
      cnt  <= cnt_nx;
      tick <= tick_nx;
      dclk <= dclk_nx;
    end
  end

endmodule

// File: rtl/clock_divider_multi.sv
// Multi-channel clock divider: decodes configuration writes to one channel
// and fans SYNC out to all channels. Outputs are data/enables, never clocks.
module clock_divider_multi
  import clock_divider_multi_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 16,
  parameter int SELW     = clog2_min1(CHANNELS)
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                CFG_WE,
  input  logic [SELW-1:0]     CFG_SEL,
  input  logic [WIDTH-1:0]    CFG_DIV,
  input  logic                CFG_EN,
  input  logic                SYNC,
  output logic [CHANNELS-1:0] TICK,
  output logic [CHANNELS-1:0] DCLK
);

  logic [CHANNELS-1:0] wr_sel;

  // One write strobe per channel; a selector at or beyond CHANNELS matches nothing.
  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      wr_sel[i] = CFG_WE && (CFG_SEL == SELW'(i));
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    clock_divider_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk    (CLK),
      .rst_n  (RESET),
      .wr     (wr_sel[g]),
      .cfg_div(CFG_DIV),
      .cfg_en (CFG_EN),
      .sync   (SYNC),
      .tick   (TICK[g]),
      .dclk   (DCLK[g])
    );
  end

endmodule

// File: doc/clock_divider_multi.md
CLOCK_DIVIDER_MULTI -- requirements
Module: clock_divider_multi

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of independent divider channels (1..16).
REQ-002 SHALL have parameter WIDTH, default 16, bit width of each divide ratio and counter (2..32).
REQ-003 SHALL have parameter SELW, default 2, width of CFG_SEL, equal to clog2(CHANNELS) with a minimum of 1.
REQ-004 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port RESET, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-006 SHALL have port CFG_WE, input, 1 bit: configuration write strobe, sampled on the CLK rising edge.
REQ-007 SHALL have port CFG_SEL, input, SELW bits: channel index for the write.
REQ-008 SHALL have port CFG_DIV, input, WIDTH bits: divide ratio to write.
REQ-009 SHALL have port CFG_EN, input, 1 bit: channel enable to write.
REQ-010 SHALL have port SYNC, input, 1 bit: phase-align strobe for all channels.
REQ-011 SHALL have port TICK, output, CHANNELS bits: one-cycle enable pulse per channel.
REQ-012 SHALL have port DCLK, output, CHANNELS bits: near-50% divided square wave per channel, registered.

Function
REQ-013 SHALL give each channel the following registers: pending div (PDIV), active div (ADIV), enable (EN), and counter (CNT, range 0..ADIV-1).
REQ-014 SHALL, on CFG_WE with CFG_SEL < CHANNELS, write CFG_DIV to PDIV and CFG_EN to EN of the selected channel.
REQ-015 SHALL ignore a write with CFG_SEL >= CHANNELS, leaving all state unchanged.
REQ-016 SHALL, when a channel is disabled, also load CFG_DIV into ADIV on the write and set CNT to 0 (immediate load).
REQ-017 SHALL, when a channel is enabled and ADIV >= 2, increment CNT each cycle and wrap from ADIV-1 to 0; at the wrap, ADIV <= PDIV, giving a glitch-free ratio change at the period boundary.
REQ-018 SHALL drive TICK[i] high for exactly one cycle when CNT wraps.
REQ-019 SHALL produce the first TICK in the cycle following the ADIV-th rising edge after the enabling write edge, and every ADIV cycles thereafter.
REQ-020 SHALL register DCLK[i] as (CNT_next < ADIV>>1); an odd ADIV therefore gives a low phase one cycle longer than the high phase.
REQ-021 SHALL, when ADIV is 0 or 1 and the channel is enabled, hold TICK[i] = 1 every cycle and DCLK[i] = 0, with CNT held at 0.
REQ-022 SHALL, on the cycle after a disabling write, hold TICK[i] = 0, DCLK[i] = 0 and CNT = 0; a disabling write SHALL truncate any in-progress period.
REQ-023 SHALL, on SYNC, set CNT = 0 and ADIV <= PDIV for every enabled channel, suppressing any TICK that would have occurred on that edge.
REQ-024 SHALL resolve CFG_WE and SYNC on the same edge with the write taking effect first: the written PDIV is the value loaded by SYNC.
REQ-025 SHALL restart CNT from 0 when EN transitions 0 to 1.
REQ-026 SHALL NOT gate or derive any clock from CLK: DCLK is data, and TICK is the intended downstream enable.

Reset
REQ-027 SHALL, while RESET = 0, immediately (asynchronously) force PDIV = ADIV = 2, EN = 0, CNT = 0, TICK = 0 and DCLK = 0 for all channels.
REQ-028 SHALL, on RESET release, perform no action until the first write or SYNC.
REQ-029 SHALL, on reset mid-period, abandon the period with no residual TICK.

Structure
REQ-030 SHALL place the DIV_RESET (2) constant and the clog2 helper in the shared clock-utility include file.
REQ-031 SHALL implement one channel (PDIV, ADIV, EN, CNT, TICK, DCLK) as sub-module clock_divider_channel, instantiated CHANNELS times via generate.
REQ-032 SHALL decode the write and fan out SYNC in the top level only.

Verification
REQ-033 SHALL cover: reset, then write ch0 DIV=4 EN=1 -> TICK[0] high every 4th cycle, and DCLK[0] pattern 1100 repeating.
REQ-034 SHALL cover: ch1 DIV=5 enabled, then rewrite DIV=3 mid-period -> the current 5-cycle period completes, then the period becomes 3 and DCLK[1] follows 100.
REQ-035 SHALL cover: ch2 DIV=1 enabled -> TICK[2] constantly 1 and DCLK[2] constantly 0; then DIV=0 -> same behaviour.
REQ-036 SHALL cover: ch0 DIV=4 and ch3 DIV=6 running, SYNC pulsed -> both CNT = 0, both first TICKs aligned 4 and 6 cycles later, and the coincident TICK suppressed.
REQ-037 SHALL cover: RESET driven low mid-period between CLK edges -> TICK and DCLK go 0 without waiting for a clock edge; after release, no TICK until rewritten.
REQ-038 SHALL cover: a write with CFG_SEL = CHANNELS (when CHANNELS = 3) -> no channel state changes.
